// File: rtl/mem_port_ctrl_if.sv
// Request/response and RAM-side signal bundle for mem_port_ctrl.
// The slave modport is the controller's view; master is the processor/RAM side.
interface mem_port_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              stall;
  logic              ready;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_douta;
  logic              mem_web;
  logic [ADDR_W-1:0] mem_addrb;
  logic [DATA_W-1:0] mem_dinb;
  logic [DATA_W-1:0] mem_doutb;

  modport slave (
    input  stall, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_douta, mem_doutb,
    output ready, if_data, if_valid, d_rdata, d_valid,
           mem_wea, mem_addra, mem_dina, mem_web, mem_addrb, mem_dinb
  );

  modport master (
    output stall, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_douta, mem_doutb,
    input  ready, if_data, if_valid, d_rdata, d_valid,
           mem_wea, mem_addra, mem_dina, mem_web, mem_addrb, mem_dinb
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Maps fetch/data requests onto a dual-port BRAM (port A read-only, port B read/write), 1-cycle read latency.
// stall freezes acceptance, RAM addresses and valids; optional post-reset zero-fill holds ready low.
module mem_port_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_ctrl_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] last_a_q, last_a_d;
  logic [ADDR_W-1:0] last_b_q, last_b_d;
  logic              if_vld_q, d_vld_q;
  logic              fwd_q;
  logic [DATA_W-1:0] fwd_data_q;

  logic run, acc, if_acc, d_acc, collide;
  logic if_valid_w, d_valid_w;

  assign run     = (state_q == RUN);
  assign acc     = run && !bus.stall && !reset;
  assign if_acc  = acc && bus.if_req;
  assign d_acc   = acc && bus.d_req;
  assign collide = if_acc && d_acc && bus.d_we && (bus.d_addr == bus.if_addr);

  assign clr_cnt_d = clr_cnt_q + 1'b1;
  assign last_a_d  = if_acc ? bus.if_addr : last_a_q;
  assign last_b_d  = d_acc  ? bus.d_addr  : last_b_q;

  // Port A never writes; port B is owned by the zero-fill sweep while clearing.
  assign bus.mem_wea   = 1'b0;
  assign bus.mem_dina  = '0;
  assign bus.mem_addra = last_a_d;
  assign bus.mem_addrb = run ? last_b_d : clr_cnt_q[ADDR_W-1:0];
  assign bus.mem_web   = run ? (d_acc && bus.d_we) : 1'b1;
  assign bus.mem_dinb  = d_acc ? bus.d_wdata : '0;

  assign bus.ready    = acc;
  assign if_valid_w   = if_vld_q && !reset;
  assign d_valid_w    = d_vld_q && !reset;
  assign bus.if_valid = if_valid_w;
  assign bus.d_valid  = d_valid_w;
  assign bus.if_data  = if_valid_w ? (fwd_q ? fwd_data_q : bus.mem_douta) : '0;
  assign bus.d_rdata  = d_valid_w ? bus.mem_doutb : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt_q  <= '0;
      last_a_q   <= '0;
      last_b_q   <= '0;
      if_vld_q   <= 1'b0;
      d_vld_q    <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          // Carry into the extra bit means the last address was just written.
          if (clr_cnt_d[ADDR_W]) state_q <= RUN;
        end
        RUN: begin
          if (acc) begin
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
            if_vld_q <= bus.if_req;
            d_vld_q  <= bus.d_req && !bus.d_we;
            if (if_acc) begin
              fwd_q <= collide;
              if (collide) fwd_data_q <= bus.d_wdata;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with zero-fill enabled and a behavioural dual-port RAM.
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic preload;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] ram [1024];

  mem_port_ctrl_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  mem_port_ctrl #(.ADDR_W(10), .DATA_W(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Port A reads old data on a cross-port collision; port B is write-first.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'hFFFF;
    end else if (bus.mem_web) begin
      ram[bus.mem_addrb] <= bus.mem_dinb;
    end
    bus.mem_douta <= ram[bus.mem_addra];
    bus.mem_doutb <= bus.mem_web ? bus.mem_dinb : ram[bus.mem_addrb];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic wait_clear_done(input string name);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL %s: ready low for %0d cycles, expected 1024", name, n);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    preload = 1'b1;
    bus.stall = 1'b0;
    idle();
    tick();
    preload = 1'b0;
    tick();
    checks++; if (bus.ready !== 1'b0)     begin errors++; $display("FAIL rst_ready: got %b exp 0", bus.ready); end
    checks++; if (bus.if_valid !== 1'b0)  begin errors++; $display("FAIL rst_if_valid: got %b exp 0", bus.if_valid); end
    checks++; if (bus.d_valid !== 1'b0)   begin errors++; $display("FAIL rst_d_valid: got %b exp 0", bus.d_valid); end
    checks++; if (bus.if_data !== 16'h0)  begin errors++; $display("FAIL rst_if_data: got %h exp 0000", bus.if_data); end
    checks++; if (bus.d_rdata !== 16'h0)  begin errors++; $display("FAIL rst_d_rdata: got %h exp 0000", bus.d_rdata); end
    checks++; if (bus.mem_web !== 1'b1)   begin errors++; $display("FAIL rst_mem_web: got %b exp 1", bus.mem_web); end
    checks++; if (bus.mem_addrb !== 10'h0) begin errors++; $display("FAIL rst_mem_addrb: got %h exp 000", bus.mem_addrb); end
    checks++; if (bus.mem_wea !== 1'b0 || bus.mem_dina !== 16'h0) begin
      errors++; $display("FAIL rst_port_a_wr: wea %b dina %h exp 0/0000", bus.mem_wea, bus.mem_dina);
    end
    reset = 1'b0;
    wait_clear_done("clear_cycles");
  endtask

  task automatic test_clear_loads();
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
    for (int i = 0; i < 3; i++) begin
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = addrs[i];
      tick();
      checks++;
      if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'h0000) begin
        errors++;
        $display("FAIL clear_load@%0d: valid %b data %h exp 1/0000", addrs[i], bus.d_valid, bus.d_rdata);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_fill_fetch();
    int bad;
    logic [15:0] exp_d;
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'(a); bus.d_wdata = 16'(1024 - a);
      tick();
      if (bus.d_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL store_dvalid: %0d store cycles had d_valid=1, exp 0", bad); end
    idle();
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      bus.if_req = 1'b1; bus.if_addr = 10'(a);
      exp_d = 16'(1024 - a);
      tick();
      if (bus.if_valid !== 1'b1 || bus.if_data !== exp_d) begin
        if (bad == 0)
          $display("FAIL fetch_stream@%0d: valid %b data %h exp 1/%h", a, bus.if_valid, bus.if_data, exp_d);
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL fetch_stream: %0d bad fetches, exp 0", bad); end
    idle();
    tick();
    checks++;
    if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle: if_valid %b exp 0", bus.if_valid); end
  endtask

  task automatic test_collision();
    bus.if_req = 1'b1; bus.if_addr = 10'h155;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h155; bus.d_wdata = 16'hBEEF;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_data !== 16'hBEEF) begin
      errors++; $display("FAIL collide_fwd: valid %b data %h exp 1/beef", bus.if_valid, bus.if_data);
    end
    checks++;
    if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL collide_dvalid: got %b exp 0", bus.d_valid); end
    idle();
    bus.if_req = 1'b1; bus.if_addr = 10'h156;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h155;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_data !== 16'h02AA) begin
      errors++; $display("FAIL after_collide_fetch: valid %b data %h exp 1/02aa", bus.if_valid, bus.if_data);
    end
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL collide_ram: valid %b data %h exp 1/beef", bus.d_valid, bus.d_rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_stall();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h010; bus.d_wdata = 16'h1234;
    tick();
    bus.d_we = 1'b0;
    tick();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'h1234) begin
      errors++; $display("FAIL stall_preload: valid %b data %h exp 1/1234", bus.d_valid, bus.d_rdata);
    end
    bus.stall = 1'b1;
    bus.d_we = 1'b1; bus.d_wdata = 16'h9999;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'h1234) begin
        errors++; $display("FAIL stall_hold%0d: valid %b data %h exp 1/1234", c, bus.d_valid, bus.d_rdata);
      end
      checks++;
      if (bus.ready !== 1'b0 || bus.mem_web !== 1'b0 || bus.mem_addrb !== 10'h010) begin
        errors++; $display("FAIL stall_ports%0d: ready %b web %b addrb %h exp 0/0/010", c, bus.ready, bus.mem_web, bus.mem_addrb);
      end
    end
    bus.stall = 1'b0;
    bus.d_we = 1'b0;
    tick();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'h1234) begin
      errors++; $display("FAIL stall_store_dropped: valid %b data %h exp 1/1234", bus.d_valid, bus.d_rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h3FF; bus.d_wdata = 16'h0042;
    tick();
    checks++;
    if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL b2b_store_valid: got %b exp 0", bus.d_valid); end
    bus.d_we = 1'b0;
    tick();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'h0042) begin
      errors++; $display("FAIL b2b_load: valid %b data %h exp 1/0042", bus.d_valid, bus.d_rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midrun();
    bus.if_req = 1'b1; bus.if_addr = 10'h005;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_data !== 16'h03FB) begin
      errors++; $display("FAIL midrun_fetch: valid %b data %h exp 1/03fb", bus.if_valid, bus.if_data);
    end
    idle();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_data !== 16'h0) begin
      errors++; $display("FAIL midrun_drop: valid %b data %h exp 0/0000", bus.if_valid, bus.if_data);
    end
    checks++;
    if (bus.ready !== 1'b0 || bus.mem_addra !== 10'h0 || bus.mem_web !== 1'b1) begin
      errors++; $display("FAIL midrun_state: ready %b addra %h web %b exp 0/000/1", bus.ready, bus.mem_addra, bus.mem_web);
    end
    reset = 1'b0;
    wait_clear_done("midrun_clear_cycles");
  endtask

  initial begin
    test_reset();
    test_clear_loads();
    test_fill_fetch();
    test_collision();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
